// File: rtl/segment_scan_decoder_pkg.sv
// Shared constants for the multiplexed 7-segment clock scanner.
// Holds segment patterns, digit slot indices and the scan FSM state type.
// No logic latency; pure definitions and helper functions.
package segment_scan_decoder_pkg;

    // Active-high segment patterns, bit0 = a ... bit6 = g
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;

    // Digit slot index = bit position of the one-hot digit select
    localparam int MIN_ONES = 0;
    localparam int MIN_TENS = 1;
    localparam int HR_ONES  = 2;
    localparam int HR_TENS  = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HELD   = 2'd2
    } state_t;

    // Bit position of the highest set bit; only meaningful for one-hot input
    function automatic logic [1:0] sel_index(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/segment_scan_decoder_seg7_decode.sv
// Maps a 7-segment pattern to a BCD digit and a valid flag.
// Latency: combinational.
// Backpressure: none; output follows input continuously.
module seg7_decode
    import segment_scan_decoder_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] digit,
    output logic       valid
);

    // Exact-match lookup; anything not in the table is flagged invalid
    always_comb begin
        digit = 4'd0;
        valid = 1'b1;
        case (pattern)
            SEG_0:   digit = 4'd0;
            SEG_1:   digit = 4'd1;
            SEG_2:   digit = 4'd2;
            SEG_3:   digit = 4'd3;
            SEG_4:   digit = 4'd4;
            SEG_5:   digit = 4'd5;
            SEG_6:   digit = 4'd6;
            SEG_7:   digit = 4'd7;
            SEG_8:   digit = 4'd8;
            SEG_9:   digit = 4'd9;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/segment_scan_decoder.sv
// Reassembles an HH:MM time from a scanned 4-digit 7-segment display bus.
// Latency: frame_valid/frame_err one cycle after the fourth digit is accepted.
// Backpressure: none; the scan bus is free-running and sampled every cycle.
module segment_scan_decoder
    import segment_scan_decoder_pkg::*;
#(
    parameter int STABLE_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  bytee,
    input  logic [6:0]  segment,
    output logic [11:0] data_out,
    output logic        frame_valid,
    output logic        frame_err,
    output logic        select_err
);

    localparam logic [4:0] STABLE_W = 5'(STABLE_CYCLES);

    state_t     state;
    logic [3:0] cnt;
    logic [3:0] sel_q;
    logic [3:0] mask;
    logic [3:0] digit_q [4];
    logic [3:0] dvalid_q;

    logic       multi_hot;
    logic       one_hot;
    logic       accept;
    logic [3:0] dec_digit;
    logic       dec_valid;
    logic [6:0] min_bin;
    logic [6:0] hr_bin;
    logic       frame_good;

    seg7_decode u_seg7_decode (
        .pattern (segment),
        .digit   (dec_digit),
        .valid   (dec_valid)
    );

    // Select classification and the digit-accept decision for this edge
    always_comb begin
        multi_hot = (bytee & (bytee - 4'd1)) != 4'd0;
        one_hot   = (bytee != 4'd0) && !multi_hot;
        accept    = 1'b0;
        if (!multi_hot) begin
            if (state == IDLE && one_hot && STABLE_W == 5'd1)
                accept = 1'b1;
            else if (state == SETTLE && bytee == sel_q && ({1'b0, cnt} + 5'd1) >= STABLE_W)
                accept = 1'b1;
        end
    end

    // Frame arithmetic stays 7 bits wide so out-of-range values are caught before truncation
    always_comb begin
        min_bin    = {3'b000, digit_q[MIN_TENS]} * 7'd10 + {3'b000, digit_q[MIN_ONES]};
        hr_bin     = {3'b000, digit_q[HR_TENS]}  * 7'd10 + {3'b000, digit_q[HR_ONES]};
        frame_good = (&dvalid_q) && (min_bin <= 7'd59) && (hr_bin <= 7'd23);
    end

    // Scan FSM, digit capture, frame evaluation and status outputs
    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            sel_q       <= 4'd0;
            mask        <= 4'd0;
            dvalid_q    <= 4'd0;
            for (int i = 0; i < 4; i++) digit_q[i] <= 4'd0;
            data_out    <= 12'h000;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            select_err  <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;

            // A full mask is reported one edge later unless a multi-hot select aborts it
            if (mask == 4'hF) begin
                mask <= 4'd0;
                if (!multi_hot) begin
                    if (frame_good) begin
                        data_out    <= {hr_bin[5:0], min_bin[5:0]};
                        frame_valid <= 1'b1;
                    end else begin
                        frame_err   <= 1'b1;
                    end
                end
            end

            if (multi_hot) begin
                select_err <= 1'b1;
                mask       <= 4'd0;
                state      <= IDLE;
                cnt        <= 4'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (one_hot) begin
                            sel_q <= bytee;
                            cnt   <= 4'd1;
                            state <= accept ? HELD : SETTLE;
                        end
                    end
                    SETTLE: begin
                        if (bytee == sel_q) begin
                            cnt <= cnt + 4'd1;
                            if (accept) state <= HELD;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    HELD: begin
                        if (bytee != sel_q) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end

            if (accept) begin
                digit_q[sel_index(bytee)]  <= dec_digit;
                dvalid_q[sel_index(bytee)] <= dec_valid;
                mask                       <= mask | bytee;
            end
        end
    end

endmodule

// File: tb/tb_segment_scan_decoder.sv
// Randomized and directed checks of the scan decoder against a run-length reference model.
// Latency: expectations are compared 1 time unit after every rising edge.
// Backpressure: none; the bench drives one bus value per clock cycle.
module tb_segment_scan_decoder;

    localparam int STABLE = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  bytee = 4'd0;
    logic [6:0]  segment = 7'd0;
    logic [11:0] data_out;
    logic        frame_valid;
    logic        frame_err;
    logic        select_err;

    segment_scan_decoder #(.STABLE_CYCLES(STABLE)) dut (
        .clock       (clock),
        .reset       (reset),
        .bytee       (bytee),
        .segment     (segment),
        .data_out    (data_out),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .select_err  (select_err)
    );

    always #5 clock = ~clock;

    int n_total = 0;
    int n_pass  = 0;
    int obs_fv  = 0;
    int obs_fe  = 0;

    logic [6:0] pat [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // Reference model state: length of the current select run and captured digits
    logic [3:0]  m_run_val;
    int          m_run_len;
    int          m_dig [4];
    bit          m_dv [4];
    logic [3:0]  m_got;
    bit          m_pend;
    logic [11:0] e_data;
    bit          e_fv, e_fe, e_serr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int popcount4(input logic [3:0] v);
        return int'(v[0]) + int'(v[1]) + int'(v[2]) + int'(v[3]);
    endfunction

    task automatic model_reset();
        m_run_val = 4'd0; m_run_len = 0; m_got = 4'd0; m_pend = 1'b0;
        for (int i = 0; i < 4; i++) begin m_dig[i] = 0; m_dv[i] = 1'b0; end
        e_data = 12'h000; e_fv = 1'b0; e_fe = 1'b0; e_serr = 1'b0;
    endtask

    // One clock edge of behaviour: a one-hot run after a blank is accepted when it reaches STABLE cycles
    task automatic model_edge(input logic [3:0] b, input logic [6:0] s);
        bit mh;
        int mins, hrs, idx;
        e_fv = 1'b0; e_fe = 1'b0;
        mh = popcount4(b) >= 2;
        if (m_pend) begin
            m_pend = 1'b0;
            if (!mh) begin
                mins = m_dig[1] * 10 + m_dig[0];
                hrs  = m_dig[3] * 10 + m_dig[2];
                if (m_dv[0] && m_dv[1] && m_dv[2] && m_dv[3] && mins <= 59 && hrs <= 23) begin
                    e_data = 12'(hrs * 64 + mins);
                    e_fv = 1'b1;
                end else begin
                    e_fe = 1'b1;
                end
            end
        end
        if (mh) begin
            e_serr = 1'b1; m_got = 4'd0; m_run_len = 0;
        end else if (b == 4'd0) begin
            m_run_len = 0;
        end else begin
            if (b == m_run_val && m_run_len > 0) m_run_len++;
            else begin m_run_val = b; m_run_len = 1; end
            if (m_run_len == STABLE) begin
                idx = 0;
                for (int i = 0; i < 4; i++) if (b[i]) idx = i;
                m_dv[idx] = 1'b0; m_dig[idx] = 0;
                for (int d = 0; d < 10; d++) if (pat[d] == s) begin m_dv[idx] = 1'b1; m_dig[idx] = d; end
                m_got[idx] = 1'b1;
                if (m_got == 4'hF) begin m_pend = 1'b1; m_got = 4'd0; end
            end
        end
    endtask

    task automatic check_outputs();
        if (frame_valid) obs_fv++;
        if (frame_err)   obs_fe++;
        chk("data_out",    32'(data_out),    32'(e_data));
        chk("frame_valid", 32'(frame_valid), 32'(e_fv));
        chk("frame_err",   32'(frame_err),   32'(e_fe));
        chk("select_err",  32'(select_err),  32'(e_serr));
    endtask

    task automatic step(input logic [3:0] b, input logic [6:0] s);
        bytee = b; segment = s;
        @(posedge clock);
        model_edge(b, s);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        reset = 1'b0; bytee = 4'd0; segment = 7'd0;
        @(posedge clock);
        model_reset();
        #1;
        check_outputs();
        reset = 1'b1;
    endtask

    // Directed digit: constant pattern for len cycles, then blank cycles
    task automatic scan(input int idx, input logic [6:0] p, input int len, input int blank);
        for (int i = 0; i < len; i++) step(4'(1 << idx), p);
        for (int i = 0; i < blank; i++) step(4'd0, 7'($urandom));
    endtask

    task automatic scan_time(input int h, input int m);
        scan(0, pat[m % 10], 3, 1);
        scan(1, pat[m / 10], 3, 1);
        scan(2, pat[h % 10], 3, 1);
        scan(3, pat[h / 10], 3, 1);
    endtask

    int fv0, fe0, len, blank, kind, idx, dval;
    logic [3:0] mh;
    logic [6:0] p;
    bit force_mh;

    initial begin
        model_reset();
        do_reset();
        chk("rst_data", 32'(data_out), 32'h000);
        chk("rst_fv",   32'(frame_valid), 32'd0);
        chk("rst_serr", 32'(select_err), 32'd0);

        // 12:34 scanned as 4,3,2,1
        fv0 = obs_fv; fe0 = obs_fe;
        scan_time(12, 34);
        chk("t1234_fv_cnt", 32'(obs_fv - fv0), 32'd1);
        chk("t1234_fe_cnt", 32'(obs_fe - fe0), 32'd0);
        chk("t1234_data",   32'(data_out), 32'h322);

        // One-cycle digit is ignored; frame completes only after a real min-ones digit
        fv0 = obs_fv;
        scan(0, pat[5], 1, 1);
        scan(1, pat[3], 3, 1); scan(2, pat[2], 3, 1); scan(3, pat[1], 3, 1);
        chk("short_no_pulse", 32'(obs_fv - fv0), 32'd0);
        scan(0, pat[4], 2, 1);
        chk("short_then_fv", 32'(obs_fv - fv0), 32'd1);
        chk("short_data",    32'(data_out), 32'h322);

        // Invalid hour-ones pattern
        fv0 = obs_fv; fe0 = obs_fe;
        scan(0, pat[4], 3, 1); scan(1, pat[3], 3, 1); scan(2, 7'h40, 3, 1); scan(3, pat[1], 3, 1);
        chk("badseg_fe",   32'(obs_fe - fe0), 32'd1);
        chk("badseg_fv",   32'(obs_fv - fv0), 32'd0);
        chk("badseg_data", 32'(data_out), 32'h322);

        // Minutes 75 out of range
        fe0 = obs_fe;
        scan_time(12, 75);
        chk("min75_fe",   32'(obs_fe - fe0), 32'd1);
        chk("min75_data", 32'(data_out), 32'h322);

        // Multi-hot after two digits, then 23:59
        scan(0, pat[1], 3, 1); scan(1, pat[1], 3, 1);
        step(4'b0011, pat[8]); step(4'd0, 7'd0);
        chk("mh_serr", 32'(select_err), 32'd1);
        fv0 = obs_fv;
        scan_time(23, 59);
        chk("t2359_fv_cnt", 32'(obs_fv - fv0), 32'd1);
        chk("t2359_data",   32'(data_out), 32'h5FB);
        chk("serr_sticky",  32'(select_err), 32'd1);

        // Multi-hot on the cycle after the completing accept suppresses the frame
        fv0 = obs_fv; fe0 = obs_fe;
        scan(0, pat[0], 3, 1); scan(1, pat[0], 3, 1); scan(2, pat[0], 3, 1);
        scan(3, pat[1], 2, 0); step(4'b1100, 7'd0); step(4'd0, 7'd0);
        chk("mh_win_pulses", 32'(obs_fv + obs_fe - fv0 - fe0), 32'd0);
        chk("mh_win_data",   32'(data_out), 32'h5FB);

        // Reset after three digits; the lone fourth digit completes nothing
        scan(0, pat[1], 3, 1); scan(1, pat[1], 3, 1); scan(2, pat[1], 3, 1);
        do_reset();
        chk("rst2_data", 32'(data_out), 32'h000);
        chk("rst2_serr", 32'(select_err), 32'd0);
        fv0 = obs_fv; fe0 = obs_fe;
        scan(3, pat[1], 3, 2);
        chk("rst2_no_pulse", 32'(obs_fv + obs_fe - fv0 - fe0), 32'd0);

        // Randomized scan traffic
        force_mh = 1'b0;
        for (int r = 0; r < 600; r++) begin
            kind = force_mh ? 99 : int'($urandom_range(0, 99));
            force_mh = 1'b0;
            if (kind < 2) begin
                do_reset();
            end else if (kind < 10 || kind == 99) begin
                mh = 4'd0;
                while (popcount4(mh) < 2) mh = 4'($urandom);
                len = $urandom_range(1, 2);
                for (int i = 0; i < len; i++) step(mh, 7'($urandom));
                blank = $urandom_range(1, 2);
                for (int i = 0; i < blank; i++) step(4'd0, 7'($urandom));
            end else begin
                idx = $urandom_range(0, 3);
                case (idx)
                    0: dval = $urandom_range(0, 9);
                    1: dval = $urandom_range(0, 6);
                    2: dval = $urandom_range(0, 9);
                    default: dval = $urandom_range(0, 2);
                endcase
                p = ($urandom_range(0, 9) == 0) ? 7'($urandom) : pat[dval];
                len = ($urandom_range(0, 5) == 0) ? 1 : int'($urandom_range(2, 3));
                for (int i = 0; i < len; i++)
                    step(4'(1 << idx), (i == STABLE - 1) ? p : 7'($urandom));
                blank = $urandom_range(0, 2);
                if (blank == 0) force_mh = 1'b1;
                for (int i = 0; i < blank; i++) step(4'd0, 7'($urandom));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
